// File: rtl/counter.sv
// Saturating up-counter with count enable.
// Clears synchronously on active-low reset and holds at all-ones.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             satEn,
  output logic [WIDTH-1:0] val_out
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt;

  // Reset wins over everything, so an unknown enable cannot leak into the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (satEn && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= cnt;
    end
  end

  assign val_out = cnt;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter at WIDTH 4, 1 and 8.
// Stimulus queues expected values; a monitor pops one per edge.
module tb_counter;

  typedef struct {
    int         dut;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b0, en4 = 1'b0;
  logic       rst1 = 1'b0, en1 = 1'b0;
  logic       rst8 = 1'b0, en8 = 1'b0;
  logic [3:0] v4;
  logic [0:0] v1;
  logic [7:0] v8;

  counter #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(rst4), .satEn(en4), .val_out(v4)
  );
  counter #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(rst1), .satEn(en1), .val_out(v1)
  );
  counter #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(rst8), .satEn(en8), .val_out(v8)
  );

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  // One queued expectation per rising edge, sampled 1 time unit later.
  initial begin : monitor
    exp_t e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        case (e.dut)
          0: act = {4'b0, v4};
          1: act = {7'b0, v1};
          default: act = v8;
        endcase
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d",
                   e.name, act, e.exp);
        end
      end
    end
  end

  task automatic drive(input int dut, input logic r,
                       input logic en);
    case (dut)
      0: begin rst4 = r; en4 = en; end
      1: begin rst1 = r; en1 = en; end
      default: begin rst8 = r; en8 = en; end
    endcase
  endtask

  task automatic cyc(input int dut, input logic r,
                     input logic en, input logic [7:0] exp,
                     input string name);
    exp_t e;
    @(negedge clk);
    drive(dut, r, en);
    e.dut = dut;
    e.exp = exp;
    e.name = name;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin : stim
    exp_t e;
    int   wait_cyc;

    // WIDTH=4: reset, count to saturation, hold.
    cyc(0, 1'b0, 1'b0, 8'd0, "w4_reset");
    for (int i = 1; i <= 20; i++)
      cyc(0, 1'b1, 1'b1, (i > 15) ? 8'd15 : 8'(i), "w4_count");
    for (int i = 0; i < 5; i++)
      cyc(0, 1'b1, 1'b0, 8'd15, "w4_hold_max");

    // Mid-range hold then resume.
    cyc(0, 1'b0, 1'b1, 8'd0, "w4_reset2");
    for (int i = 1; i <= 7; i++)
      cyc(0, 1'b1, 1'b1, 8'(i), "w4_count_mid");
    for (int i = 0; i < 3; i++)
      cyc(0, 1'b1, 1'b0, 8'd7, "w4_hold_mid");
    cyc(0, 1'b1, 1'b1, 8'd8, "w4_resume");

    // Reset beats enable, then counting restarts from 1.
    cyc(0, 1'b0, 1'b1, 8'd0, "w4_reset_prio");
    cyc(0, 1'b1, 1'b1, 8'd1, "w4_after_rst1");
    cyc(0, 1'b1, 1'b1, 8'd2, "w4_after_rst2");
    cyc(0, 1'b1, 1'b1, 8'd3, "w4_after_rst3");

    // Reset glitch between edges must be ignored.
    @(negedge clk);
    en4 = 1'b0;
    rst4 = 1'b0;
    #2;
    rst4 = 1'b1;
    e.dut = 0;
    e.exp = 8'd3;
    e.name = "w4_sync_glitch";
    q.push_back(e);
    @(posedge clk);

    // Unknown enable during reset still clears.
    cyc(0, 1'b1, 1'b1, 8'd4, "w4_pre_xrst");
    cyc(0, 1'b0, 1'bx, 8'd0, "w4_reset_xen");
    cyc(0, 1'b1, 1'b0, 8'd0, "w4_hold_zero");

    // WIDTH=1: 0, 1, 1.
    cyc(1, 1'b0, 1'b0, 8'd0, "w1_reset");
    cyc(1, 1'b1, 1'b1, 8'd1, "w1_count");
    cyc(1, 1'b1, 1'b1, 8'd1, "w1_sat");

    // WIDTH=8: saturates at 255 after 255 enabled edges.
    cyc(2, 1'b0, 1'b0, 8'd0, "w8_reset");
    for (int i = 1; i <= 257; i++)
      cyc(2, 1'b1, 1'b1, (i > 255) ? 8'd255 : 8'(i), "w8_count");

    // Drain: bounded wait for the monitor to empty the queue.
    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
